// File: rtl/membus_arbiter.sv
// membus_arbiter - shares one synchronous 16-bit memory port between the CPU and a debug/loader master
//
// Optional feature macro: MEMARB_STATS_EN (builds the stall_cnt hold-cycle counter;
// when undefined, stall_cnt is tied to zero).
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   cpu_addr/wdata/we/cs            CPU memory request
//   cpu_halted                      CPU halted (waives the minimum CPU run window)
//   cpu_hold                        freezes the CPU while debug owns the bus (registered)
//   cpu_rdata                       CPU read data (= mem_rdata)
//   dbg_req/addr/wdata/we           debug master request / transfer
//   dbg_gnt                         debug owns the bus (registered)
//   dbg_rdata, dbg_rvalid           debug read data, valid one cycle after an accepted read
//   mem_addr/wdata/we/cs, mem_rdata memory port, read data one cycle after address
//   stall_cnt                       count of CPU hold cycles (MEMARB_STATS_EN only)
module membus_arbiter #(
  parameter int AW        = 16,
  parameter int DW        = 16,
  parameter int MAX_BURST = 16,
  parameter int MIN_CPU   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          cpu_we,
  input  logic          cpu_cs,
  input  logic          cpu_halted,
  output logic          cpu_hold,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  input  logic          dbg_we,
  output logic          dbg_gnt,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_rvalid,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_cs,
  input  logic [DW-1:0] mem_rdata,
  output logic [15:0]   stall_cnt
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int GW = $clog2(MIN_CPU + 1);

  typedef enum logic [1:0] {ST_CPU, ST_DBG, ST_REPLAY} state_t;

  state_t        state, state_nx;
  logic [BW-1:0] burst_cnt;
  logic [GW-1:0] gap_cnt;
  logic [AW-1:0] saved_addr;
  logic          grant;

  assign cpu_rdata = mem_rdata;
  assign dbg_rdata = mem_rdata;

  always_comb begin
    state_nx  = state;
    grant     = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = cpu_we;
    mem_cs    = cpu_cs;
    case (state)
      ST_CPU: begin
        // The granting cycle is still a CPU memory cycle; the CPU freezes next cycle.
        if (dbg_req && (gap_cnt >= GW'(MIN_CPU) || cpu_halted)) begin
          grant    = 1'b1;
          state_nx = ST_DBG;
        end
      end
      ST_DBG: begin
        mem_addr  = dbg_addr;
        mem_wdata = dbg_wdata;
        mem_we    = dbg_we;
        mem_cs    = dbg_req;
        // The transfer accepted on the exit cycle still completes.
        if (!dbg_req || burst_cnt == BW'(MAX_BURST - 1)) begin
          state_nx = ST_REPLAY;
        end
      end
      ST_REPLAY: begin
        // Re-read the CPU's frozen address so datain is correct when hold drops.
        mem_addr = saved_addr;
        mem_we   = 1'b0;
        mem_cs   = 1'b1;
        state_nx = ST_CPU;
      end
      default: state_nx = ST_CPU;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_CPU;
      cpu_hold   <= 1'b0;
      dbg_gnt    <= 1'b0;
      dbg_rvalid <= 1'b0;
      burst_cnt  <= '0;
      gap_cnt    <= GW'(MIN_CPU);
      saved_addr <= '0;
    end else begin
      state      <= state_nx;
      cpu_hold   <= (state_nx != ST_CPU);
      dbg_gnt    <= (state_nx == ST_DBG);
      dbg_rvalid <= (state == ST_DBG) && dbg_req && !dbg_we;
      case (state)
        ST_CPU: begin
          if (gap_cnt != GW'(MIN_CPU)) gap_cnt <= gap_cnt + 1'b1;
          if (grant) saved_addr <= cpu_addr;
        end
        ST_DBG: begin
          if (dbg_req) burst_cnt <= burst_cnt + 1'b1;
        end
        ST_REPLAY: begin
          burst_cnt <= '0;
          gap_cnt   <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef MEMARB_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= 16'd0;
    end else if (cpu_hold && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_membus_arbiter.sv
// tb/tb_membus_arbiter.sv - self-checking bench for membus_arbiter
module tb_membus_arbiter;

  localparam int MIN_CPU = 4;
  localparam logic [15:0] CPU_WD = 16'hC0DE;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic        cpu_we, cpu_cs, cpu_halted, dbg_req, dbg_we;
  logic        cpu_hold, dbg_gnt, dbg_rvalid, mem_we, mem_cs;
  logic [15:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, stall_cnt;
  logic [15:0] mem_rdata;
  logic [15:0] mem [0:255];

  int checks = 0;
  int errors = 0;
  int row = 0;

  always #5 clk = ~clk;

  membus_arbiter #(.AW(16), .DW(16), .MAX_BURST(4), .MIN_CPU(MIN_CPU)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_cs(cpu_cs),
    .cpu_halted(cpu_halted), .cpu_hold(cpu_hold), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_we(dbg_we),
    .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_cs(mem_cs),
    .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
  );

  // Synchronous memory, 1-cycle read latency.
  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  typedef struct {
    logic        rst;
    logic [15:0] ca;
    logic        cwe;
    logic        halt;
    logic        dreq;
    logic [15:0] da;
    logic [15:0] dwd;
    logic        dwe;
    logic        e_hold;
    logic        e_gnt;
    logic        e_rv;
    logic [15:0] e_ma;
    logic        e_we;
    logic        e_cs;
    logic        chk;
    logic [15:0] e_rd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [15:0] ca, input logic cwe, input logic halt,
                     input logic dreq, input logic [15:0] da, input logic [15:0] dwd,
                     input logic dwe, input logic h, input logic g, input logic rv,
                     input logic [15:0] ma, input logic we, input logic cs,
                     input logic chk, input logic [15:0] rd);
    vec_t v;
    v.rst = r; v.ca = ca; v.cwe = cwe; v.halt = halt; v.dreq = dreq; v.da = da;
    v.dwd = dwd; v.dwe = dwe; v.e_hold = h; v.e_gnt = g; v.e_rv = rv; v.e_ma = ma;
    v.e_we = we; v.e_cs = cs; v.chk = chk; v.e_rd = rd;
    vecs.push_back(v);
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (row %0d): got %h, expected %h", name, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; cpu_addr = v.ca; cpu_we = v.cwe; cpu_halted = v.halt;
    dbg_req = v.dreq; dbg_addr = v.da; dbg_wdata = v.dwd; dbg_we = v.dwe;
  endtask

  initial begin
    logic [15:0] exp_stall;
    int n, burst, gap;

    for (int i = 0; i < 256; i++) mem[i] = 16'h0100 + 16'(i);
    mem[20] = 16'h1234;
    mem_rdata = 16'h0;
    cpu_wdata = CPU_WD; cpu_cs = 1'b1;
    rst = 1'b1; cpu_addr = 16'h0; cpu_we = 1'b0; cpu_halted = 1'b0;
    dbg_req = 1'b0; dbg_addr = 16'h0; dbg_wdata = 16'h0; dbg_we = 1'b0;

    //   rst ca      cwe hlt req da      dwd       dwe  hold gnt rv  ma      we cs chk rd
    add(0, 16'd1,  0, 0, 0, 16'd0,  16'h0,    0,   0, 0, 0, 16'd1,  0, 1, 0, 16'h0);
    add(0, 16'd2,  1, 0, 0, 16'd0,  16'h0,    0,   0, 0, 0, 16'd2,  1, 1, 1, 16'h0101);
    add(0, 16'd5,  0, 0, 1, 16'd10, 16'hAAAA, 1,   0, 0, 0, 16'd5,  0, 1, 0, 16'h0);
    add(0, 16'd5,  0, 0, 1, 16'd10, 16'hAAAA, 1,   1, 1, 0, 16'd10, 1, 1, 1, 16'h0105);
    add(0, 16'd5,  0, 0, 1, 16'd11, 16'hAAAB, 1,   1, 1, 0, 16'd11, 1, 1, 0, 16'h0);
    add(0, 16'd5,  0, 0, 1, 16'd12, 16'hAAAC, 1,   1, 1, 0, 16'd12, 1, 1, 0, 16'h0);
    add(0, 16'd5,  0, 0, 0, 16'd0,  16'h0,    0,   1, 1, 0, 16'd0,  0, 0, 0, 16'h0);
    add(0, 16'd5,  0, 0, 0, 16'd0,  16'h0,    0,   1, 0, 0, 16'd5,  0, 1, 0, 16'h0);
    add(0, 16'd10, 0, 0, 1, 16'd20, 16'h0,    0,   0, 0, 0, 16'd10, 0, 1, 1, 16'h0105);
    add(0, 16'd11, 0, 0, 1, 16'd20, 16'h0,    0,   0, 0, 0, 16'd11, 0, 1, 1, 16'hAAAA);
    add(0, 16'd12, 0, 0, 1, 16'd20, 16'h0,    0,   0, 0, 0, 16'd12, 0, 1, 1, 16'hAAAB);
    add(0, 16'd2,  0, 0, 1, 16'd20, 16'h0,    0,   0, 0, 0, 16'd2,  0, 1, 1, 16'hAAAC);
    add(0, 16'd6,  0, 0, 1, 16'd20, 16'h0,    0,   0, 0, 0, 16'd6,  0, 1, 1, 16'hC0DE);
    add(0, 16'd6,  0, 0, 1, 16'd20, 16'h0,    0,   1, 1, 0, 16'd20, 0, 1, 1, 16'h0106);
    add(0, 16'd6,  0, 0, 1, 16'd21, 16'h0,    0,   1, 1, 1, 16'd21, 0, 1, 1, 16'h1234);
    add(0, 16'd6,  0, 0, 1, 16'd22, 16'h0,    0,   1, 1, 1, 16'd22, 0, 1, 1, 16'h0115);
    add(0, 16'd6,  0, 0, 1, 16'd23, 16'h0,    0,   1, 1, 1, 16'd23, 0, 1, 1, 16'h0116);
    add(0, 16'd6,  0, 0, 0, 16'd0,  16'h0,    0,   1, 0, 1, 16'd6,  0, 1, 1, 16'h0117);
    add(0, 16'd7,  0, 1, 1, 16'd30, 16'h0,    0,   0, 0, 0, 16'd7,  0, 1, 1, 16'h0106);
    add(0, 16'd7,  0, 1, 1, 16'd30, 16'h0,    0,   1, 1, 0, 16'd30, 0, 1, 1, 16'h0107);
    add(0, 16'd7,  0, 1, 1, 16'd31, 16'hBEEF, 1,   1, 1, 1, 16'd31, 1, 1, 1, 16'h011E);
    add(1, 16'd7,  0, 1, 1, 16'd32, 16'h0,    0,   1, 1, 0, 16'd32, 0, 1, 0, 16'h0);
    add(0, 16'd7,  0, 0, 0, 16'd0,  16'h0,    0,   0, 0, 0, 16'd7,  0, 1, 0, 16'h0);
    add(0, 16'd31, 0, 0, 0, 16'd0,  16'h0,    0,   0, 0, 0, 16'd31, 0, 1, 0, 16'h0);
    add(0, 16'd0,  0, 0, 0, 16'd0,  16'h0,    0,   0, 0, 0, 16'd0,  0, 1, 1, 16'hBEEF);

    repeat (2) @(posedge clk);
    exp_stall = 16'd0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      row = i;
      drive(vecs[i]);
      #1;
      chk16("cpu_hold",   {15'd0, cpu_hold},   {15'd0, vecs[i].e_hold});
      chk16("dbg_gnt",    {15'd0, dbg_gnt},    {15'd0, vecs[i].e_gnt});
      chk16("dbg_rvalid", {15'd0, dbg_rvalid}, {15'd0, vecs[i].e_rv});
      chk16("mem_addr",   mem_addr,            vecs[i].e_ma);
      chk16("mem_we",     {15'd0, mem_we},     {15'd0, vecs[i].e_we});
      chk16("mem_cs",     {15'd0, mem_cs},     {15'd0, vecs[i].e_cs});
      if (vecs[i].e_we) chk16("mem_wdata", mem_wdata, vecs[i].e_hold ? vecs[i].dwd : CPU_WD);
      if (vecs[i].chk) begin
        chk16("cpu_rdata", cpu_rdata, vecs[i].e_rd);
        chk16("dbg_rdata", dbg_rdata, vecs[i].e_rd);
      end
`ifdef MEMARB_STATS_EN
      chk16("stall_cnt", stall_cnt, exp_stall);
`else
      chk16("stall_cnt", stall_cnt, 16'd0);
`endif
      if (vecs[i].rst) exp_stall = 16'd0;
      else if (vecs[i].e_hold) exp_stall = exp_stall + 16'd1;
    end

    // Held request: burst must end at MAX_BURST, then a full CPU window before re-grant.
    row = 100;
    cpu_addr = 16'd0; cpu_halted = 1'b0;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h40; dbg_wdata = 16'h5A5A;
    n = 0;
    while (!dbg_gnt && n < 20) begin @(negedge clk); #1; n++; end
    chk16("first_grant", {15'd0, dbg_gnt}, 16'd1);
    burst = 0; n = 0;
    while (dbg_gnt && n < 40) begin
      if (mem_cs && mem_we) burst++;
      @(negedge clk); dbg_addr = dbg_addr + 16'd1; #1; n++;
    end
    chk16("burst_len", 16'(burst), 16'd4);
    n = 0;
    while (cpu_hold && n < 20) begin @(negedge clk); #1; n++; end
    gap = 0; n = 0;
    while (!cpu_hold && n < 40) begin gap++; @(negedge clk); #1; n++; end
    chk16("regrant", {15'd0, cpu_hold}, 16'd1);
    chk16("min_gap_ok", {15'd0, gap >= MIN_CPU}, 16'd1);
    dbg_req = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk16("idle_hold", {15'd0, cpu_hold}, 16'd0);
    chk16("mem_40", mem[8'h40], 16'h5A5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
